// File: rtl/compare_sequencer.sv
// Drives operand pairs into an external combinational equality comparator, samples its
// result one cycle later and returns it over a valid/ready port, with saturating counters.
module compare_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             equal,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_equal,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResult
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q;
    logic             in_ready_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             res_equal_q;
    logic [CNT_W-1:0] pair_count_q;
    logic [CNT_W-1:0] match_count_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    // Handshake flags are registered alongside the state so they never depend
    // combinationally on in_valid or res_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            in_ready_q    <= 1'b1;
            res_valid_q   <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            res_equal_q   <= 1'b0;
            pair_count_q  <= '0;
            match_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        in_ready_q <= 1'b0;
                        state_q    <= StDrive;
                    end
                end
                StDrive: begin
                    // Comparator has had a full cycle to settle on a_q/b_q.
                    res_equal_q  <= equal;
                    pair_count_q <= sat_inc(pair_count_q);
                    if (equal) begin
                        match_count_q <= sat_inc(match_count_q);
                    end
                    res_valid_q <= 1'b1;
                    state_q     <= StResult;
                end
                StResult: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign res_valid   = res_valid_q;
    assign A           = a_q;
    assign B           = b_q;
    assign res_equal   = res_equal_q;
    assign pair_count  = pair_count_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Directed and randomized bench for compare_sequencer; a default-width and a 3-bit-counter
// instance share stimulus, each driven by its own behavioural comparator.
module tb_compare_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       res_ready = 1'b0;
    logic [3:0] in_a      = '0;
    logic [3:0] in_b      = '0;
    logic       noise     = 1'b0;

    logic       rdy_m, vld_m, req_m, eq_m;
    logic [3:0] a_m, b_m;
    logic [7:0] pc_m, mc_m;
    logic       rdy_s, vld_s, req_s, eq_s;
    logic [3:0] a_s, b_s;
    logic [2:0] pc_s, mc_s;

    int n_cmp = 0;
    int n_err = 0;
    int exp_n = 0;
    int exp_m = 0;

    // Comparator model; outside the operand-settling cycle it outputs noise.
    assign eq_m = (!rdy_m && !vld_m) ? (a_m == b_m) : noise;
    assign eq_s = (!rdy_s && !vld_s) ? (a_s == b_s) : noise;

    always @(negedge clk) noise <= 1'($urandom_range(1));

    compare_sequencer #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m),
        .in_a(in_a), .in_b(in_b), .A(a_m), .B(b_m), .equal(eq_m),
        .res_valid(vld_m), .res_ready(res_ready), .res_equal(req_m),
        .pair_count(pc_m), .match_count(mc_m)
    );

    compare_sequencer #(.WIDTH(4), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b), .A(a_s), .B(b_s), .equal(eq_s),
        .res_valid(vld_s), .res_ready(res_ready), .res_equal(req_s),
        .pair_count(pc_s), .match_count(mc_s)
    );

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_pc8"}, 32'(pc_m), sat(exp_n, 255));
        chk({tag, "_mc8"}, 32'(mc_m), sat(exp_m, 255));
        chk({tag, "_pc3"}, 32'(pc_s), sat(exp_n, 7));
        chk({tag, "_mc3"}, 32'(mc_s), sat(exp_m, 7));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 4'hF;
        in_b      = 4'hF;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(rdy_m), 1);
        chk("rst_valid", 32'(vld_m), 0);
        chk("rst_A", 32'(a_m), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        exp_n    = 0;
        exp_m    = 0;
        tick();
        chk("post_rst_ready", 32'(rdy_m), 1);
        chk("post_rst_valid", 32'(vld_m), 0);
        chk("post_rst_A", 32'(a_m), 0);
        chk("post_rst_B", 32'(b_m), 0);
        chk("post_rst_req", 32'(req_m), 0);
        chk("post_rst_sat_ready", 32'(rdy_s), 1);
        chk_counts("post_rst");
    endtask

    // One full transaction: accept, settle, result held for 'stall' extra cycles,
    // consumed with a competing input offered (ja/jb) that must not be taken.
    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input int stall,
                             input logic [3:0] ja, input logic [3:0] jb);
        logic eq;
        eq = (a == b);
        for (int k = 0; k < 8 && rdy_m !== 1'b1; k++) tick();
        chk("ready_before_send", 32'(rdy_m), 1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        res_ready = 1'($urandom_range(1));
        tick();
        exp_n++;
        if (eq) exp_m++;
        chk("drive_ready", 32'(rdy_m), 0);
        chk("drive_valid", 32'(vld_m), 0);
        chk("drive_A", 32'(a_m), 32'(a));
        chk("drive_B", 32'(b_m), 32'(b));
        in_a      = ja;
        in_b      = jb;
        res_ready = (stall == 0);
        tick();
        chk("res_valid", 32'(vld_m), 1);
        chk("res_equal", 32'(req_m), 32'(eq));
        chk("sat_res_equal", 32'(req_s), 32'(eq));
        chk_counts("res");
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(1));
            tick();
            chk("stall_valid", 32'(vld_m), 1);
            chk("stall_equal", 32'(req_m), 32'(eq));
            chk("stall_ready", 32'(rdy_m), 0);
            chk("stall_A", 32'(a_m), 32'(a));
            chk("stall_B", 32'(b_m), 32'(b));
            if (s == stall - 1) begin
                res_ready = 1'b1;
                in_valid  = 1'b1;
            end
        end
        in_valid = 1'b1;
        tick();
        chk("done_ready", 32'(rdy_m), 1);
        chk("done_valid", 32'(vld_m), 0);
        chk("done_A", 32'(a_m), 32'(a));
        chk("done_B", 32'(b_m), 32'(b));
        in_valid  = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] sa [5];
        logic [3:0] sb [5];
        logic [3:0] ra, rb;

        // Reset values, with a pair offered throughout reset.
        do_reset();

        // Match then mismatch.
        send_pair(4'b1010, 4'b1010, 0, 4'h1, 4'h2);
        send_pair(4'b1100, 4'b1001, 1, 4'h7, 4'h7);
        chk("mm_pc", 32'(pc_m), 2);
        chk("mm_mc", 32'(mc_m), 1);

        // Back-pressure with a competing 3/6 pair, then that pair accepted in IDLE.
        send_pair(4'hF, 4'hF, 5, 4'h3, 4'h6);
        send_pair(4'h3, 4'h6, 0, 4'h0, 4'h0);

        // Saturation of the 3-bit counters.
        do_reset();
        for (int i = 0; i < 9; i++) send_pair(4'h0, 4'h0, 0, 4'($urandom), 4'($urandom));
        chk("sat_pc3", 32'(pc_s), 7);
        chk("sat_mc3", 32'(mc_s), 7);
        chk("sat_pc8", 32'(pc_m), 9);

        // Reset during the settling cycle aborts the pair.
        do_reset();
        in_valid = 1'b1;
        in_a     = 4'h5;
        in_b     = 4'h5;
        tick();
        chk("abort_drive_A", 32'(a_m), 5);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("abort_ready", 32'(rdy_m), 1);
        chk("abort_A", 32'(a_m), 0);
        chk("abort_B", 32'(b_m), 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_valid", 32'(vld_m), 0);
            tick();
        end
        chk_counts("abort");

        // Streaming with in_valid and res_ready held high.
        do_reset();
        sa = '{4'b0000, 4'b1010, 4'b1100, 4'b1111, 4'b0011};
        sb = '{4'b0000, 4'b1010, 4'b1001, 4'b1111, 4'b0110};
        res_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = sa[i];
            in_b = sb[i];
            chk("stream_ready_hi", 32'(rdy_m), 1);
            tick();
            exp_n++;
            if (sa[i] == sb[i]) exp_m++;
            chk("stream_ready_lo1", 32'(rdy_m), 0);
            chk("stream_A", 32'(a_m), 32'(sa[i]));
            tick();
            chk("stream_ready_lo2", 32'(rdy_m), 0);
            chk("stream_valid", 32'(vld_m), 1);
            chk("stream_equal", 32'(req_m), 32'(sa[i] == sb[i]));
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        chk("stream_pc", 32'(pc_m), 5);
        chk("stream_mc", 32'(mc_m), 3);

        // Randomized pairs with random stalls and competing inputs.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(1) == 1) ? ra : 4'($urandom);
            send_pair(ra, rb, int'($urandom_range(3)), 4'($urandom), 4'($urandom));
            if ($urandom_range(3) == 0) begin
                tick();
                chk("idle_ready", 32'(rdy_m), 1);
            end
        end
        chk_counts("random_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
